// File: rtl/fp32tofp16.sv
// Two-stage FP32 -> FP16 narrowing converter (round-to-nearest-even) with
// valid/ready handshakes on both sides, one conversion per cycle.
module fp32tofp16 #(
  parameter bit SAT_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_flags
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_TINY,
    CLS_INF,
    CLS_NAN
  } cls_t;

  localparam logic [14:0] MAG_INF  = 15'h7C00;
  localparam logic [14:0] MAG_MAX  = 15'h7BFF;
  localparam logic [14:0] MAG_QNAN = 15'h7E00;

  localparam logic [3:0] FLAG_INVALID  = 4'b1000;
  localparam logic [3:0] FLAG_OVERFLOW = 4'b0100;
  localparam logic [3:0] FLAG_UNDERFLOW = 4'b0010;
  localparam logic [3:0] FLAG_INEXACT  = 4'b0001;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack and classify
  // ---------------------------------------------------------------------------
  logic [7:0]        in_exp;
  logic [22:0]       in_man;
  cls_t              in_cls;
  logic signed [8:0] in_e16;
  logic [4:0]        in_sh;

  assign in_exp = in_data[30:23];
  assign in_man = in_data[22:0];
  assign in_e16 = $signed({1'b0, in_exp}) - 9'sd112;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_cls = CLS_NORM;
    if (in_exp == 8'hFF) begin
      in_cls = (in_man != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (in_exp == 8'h00) begin
      in_cls = CLS_ZERO;
    end else if (in_exp <= 8'd112) begin
      in_cls = CLS_TINY;
    end
  end

  // Shift that aligns {1,M} to the FP16 subnormal quantum; 26 already pushes
  // every significand bit below the guard position.
  always_comb begin
    in_sh = 5'd0;
    if (in_exp <= 8'd100) begin
      in_sh = 5'd26;
    end else if (in_exp <= 8'd126) begin
      in_sh = 5'(8'd126 - in_exp);
    end
  end

  logic              s1_sign;
  cls_t              s1_cls;
  logic [23:0]       s1_sig;
  logic signed [8:0] s1_e16;
  logic [4:0]        s1_sh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_sig   <= 24'd0;
      s1_e16   <= 9'sd0;
      s1_sh    <= 5'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[31];
        s1_cls  <= in_cls;
        s1_sig  <= {1'b1, in_man};
        s1_e16  <= in_e16;
        s1_sh   <= in_sh;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round and pack
  // ---------------------------------------------------------------------------
  // Normal range: 10 kept bits, guard, sticky; the mantissa carry ripples
  // straight into the exponent field.
  logic [9:0]  norm_m;
  logic        norm_g;
  logic        norm_s;
  logic        norm_rnd;
  logic [14:0] norm_sum;
  logic        norm_ovf_pre;
  logic        norm_ovf_rnd;

  assign norm_m       = s1_sig[22:13];
  assign norm_g       = s1_sig[12];
  assign norm_s       = |s1_sig[11:0];
  assign norm_rnd     = norm_g && (norm_s || norm_m[0]);
  assign norm_sum     = {s1_e16[4:0], norm_m} + {14'd0, norm_rnd};
  assign norm_ovf_pre = (s1_e16 > 9'sd30);
  assign norm_ovf_rnd = (norm_sum[14:10] == 5'h1F);

  // Tiny range: sh >= 14 here, so only the low shift amount needs a shifter.
  logic [3:0]  tiny_sh;
  logic [35:0] tiny_ext;
  logic [9:0]  tiny_m;
  logic        tiny_g;
  logic        tiny_s;
  logic        tiny_rnd;
  logic [10:0] tiny_sum;

  assign tiny_sh  = 4'(s1_sh - 5'd14);
  assign tiny_ext = {s1_sig, 12'd0} >> tiny_sh;
  assign tiny_m   = tiny_ext[35:26];
  assign tiny_g   = tiny_ext[25];
  assign tiny_s   = |tiny_ext[24:0];
  assign tiny_rnd = tiny_g && (tiny_s || tiny_m[0]);
  assign tiny_sum = {1'b0, tiny_m} + {10'd0, tiny_rnd};

  logic [14:0] ovf_mag;
  logic [14:0] res_mag;
  logic [3:0]  res_flags;

  assign ovf_mag = SAT_MODE ? MAG_MAX : MAG_INF;

  always_comb begin
    res_mag   = 15'd0;
    res_flags = 4'd0;
    unique case (s1_cls)
      CLS_NAN: begin
        res_mag = MAG_QNAN;
        if (!s1_sig[22]) res_flags = FLAG_INVALID;
      end
      CLS_INF: begin
        res_mag = MAG_INF;
      end
      CLS_ZERO: begin
        if (s1_sig[22:0] != 23'd0) res_flags = FLAG_UNDERFLOW | FLAG_INEXACT;
      end
      CLS_NORM: begin
        if (norm_ovf_pre || norm_ovf_rnd) begin
          res_mag   = ovf_mag;
          res_flags = FLAG_OVERFLOW | FLAG_INEXACT;
        end else begin
          res_mag = norm_sum;
          if (norm_g || norm_s) res_flags = FLAG_INEXACT;
        end
      end
      CLS_TINY: begin
        // A carry into bit 10 lands on exponent field 1: the min normal.
        res_mag = {4'd0, tiny_sum};
        if (tiny_g || tiny_s) res_flags = FLAG_UNDERFLOW | FLAG_INEXACT;
      end
      default: begin
        res_mag   = 15'd0;
        res_flags = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_data  <= 16'h0000;
      out_flags <= 4'h0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= {s1_sign, res_mag};
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32tofp16.sv
// Self-checking bench for fp32tofp16: directed vectors, backpressure, reset
// mid-stream and a randomized stream against a rational-arithmetic RNE model.
module tb_fp32tofp16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [15:0] out_data_s;
  logic [3:0]  out_flags_s;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  fp32tofp16 #(.SAT_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  fp32tofp16 #(.SAT_MODE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_flags(out_flags_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the operand as sig * 2^ex, pick the FP16 quantum for its
  // binade (or the subnormal quantum 2^-24), and divide with RNE remainder rules.
  function automatic logic [19:0] ref_conv(input logic [31:0] x, input bit sat);
    bit          s;
    int          e, ex, qexp, k, be;
    longint      sig, q, r, half;
    bit          tiny, inexact, up;
    logic [14:0] mag;
    logic [3:0]  fl;
    s  = x[31];
    e  = int'(x[30:23]);
    fl = 4'h0;
    if (e == 255) begin
      if (x[22:0] != 23'd0) return {(x[22] ? 4'h0 : 4'h8), s, 15'h7E00};
      return {4'h0, s, 15'h7C00};
    end
    if (e == 0) begin
      sig  = longint'(x[22:0]);
      ex   = -149;
      tiny = 1'b1;
    end else begin
      sig  = longint'({1'b1, x[22:0]});
      ex   = e - 150;
      tiny = (e - 127) < -14;
    end
    qexp = tiny ? -24 : (e - 127 - 10);
    k    = qexp - ex;
    if (k > 62) begin
      q       = 0;
      inexact = (sig != 0);
    end else begin
      q       = sig >>> k;
      r       = sig - (q <<< k);
      half    = longint'(1) <<< (k - 1);
      up      = (r > half) || ((r == half) && q[0]);
      inexact = (r != 0);
      if (up) q = q + 1;
    end
    if (tiny) begin
      mag = 15'(q);
      fl  = inexact ? 4'h3 : 4'h0;
    end else begin
      be = e - 127 + 15;
      if (q == 2048) begin
        q  = 1024;
        be = be + 1;
      end
      if (be >= 31) begin
        mag = sat ? 15'h7BFF : 15'h7C00;
        fl  = 4'h5;
      end else begin
        mag = 15'(longint'(be) * 1024 + (q - 1024));
        fl  = {3'b000, inexact};
      end
    end
    return {fl, s, mag};
  endfunction

  // Scoreboard: inputs are recorded at the handshake, outputs checked in order.
  always @(negedge clk) begin
    logic [31:0] x;
    logic [19:0] e0, e1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_vec++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_output got=%h/%h required=none", out_data, out_flags);
        end
        if (exp_q.size() > 0) begin
          x  = exp_q.pop_front();
          e0 = ref_conv(x, 1'b0);
          e1 = ref_conv(x, 1'b1);
          n_vec++;
          assert ({out_flags, out_data} === e0) else begin
            n_err++;
            $error("FAIL conv in=%h got=%h/%h required=%h/%h", x, out_data, out_flags, e0[15:0], e0[19:16]);
          end
          n_vec++;
          assert ({out_flags_s, out_data_s} === e1) else begin
            n_err++;
            $error("FAIL conv_sat in=%h got=%h/%h required=%h/%h", x, out_data_s, out_flags_s, e1[15:0], e1[19:16]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    assert (got === req) else begin
      n_err++;
      $error("FAIL %s got=%h required=%h", tag, got, req);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("send_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic [3:0] f,
                            input logic [15:0] ds);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_data"}, {12'd0, out_flags, out_data}, {12'd0, f, d});
      chk({tag, "_sat"}, {16'd0, out_data_s}, {16'd0, ds});
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       r[30:23] = 8'h00;
      1:       r[30:23] = 8'hFF;
      2, 3:    r[30:23] = 8'($urandom_range(98, 114));
      4, 5:    r[30:23] = 8'($urandom_range(138, 145));
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) r[11:0] = 12'd0;
    return r;
  endfunction

  typedef struct {
    logic [31:0] in;
    logic [15:0] d;
    logic [3:0]  f;
    logic [15:0] ds;
  } vec_t;

  vec_t dir_vecs[$] = '{
    '{32'h3F800000, 16'h3C00, 4'h0, 16'h3C00},
    '{32'h3F801000, 16'h3C00, 4'h1, 16'h3C00},
    '{32'h3F803000, 16'h3C02, 4'h1, 16'h3C02},
    '{32'hC0490FDB, 16'hC248, 4'h1, 16'hC248},
    '{32'h477FE000, 16'h7BFF, 4'h0, 16'h7BFF},
    '{32'h477FF000, 16'h7C00, 4'h5, 16'h7BFF},
    '{32'h33800000, 16'h0001, 4'h0, 16'h0001},
    '{32'h33000000, 16'h0000, 4'h3, 16'h0000},
    '{32'h33000001, 16'h0001, 4'h3, 16'h0001},
    '{32'h387FE000, 16'h0400, 4'h3, 16'h0400},
    '{32'h00000001, 16'h0000, 4'h3, 16'h0000},
    '{32'h7F800001, 16'h7E00, 4'h8, 16'h7E00},
    '{32'hFFC00000, 16'hFE00, 4'h0, 16'hFE00},
    '{32'hFF800000, 16'hFC00, 4'h0, 16'hFC00},
    '{32'h80000000, 16'h8000, 4'h0, 16'h8000}
  };

  initial begin
    logic [15:0] hold;
    logic [19:0] ra;
    int          sent;
    int          cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed conversions, one at a time
    foreach (dir_vecs[i]) begin
      send(dir_vecs[i].in);
      expect_out($sformatf("dir_%h", dir_vecs[i].in), dir_vecs[i].d, dir_vecs[i].f, dir_vecs[i].ds);
    end

    // Backpressure: two accepted, third stalls, data held stable
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3F800000;
    @(negedge clk);
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'h40000000;
    @(negedge clk);
    chk("bp_ready_2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'h40400000;
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    ra   = ref_conv(32'h3F800000, 1'b0);
    chk("bp_head_data", 32'(out_data), 32'(ra[15:0]));
    hold = out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_stall_hold", 32'(out_data), 32'(hold));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_drain_1", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_drain_3", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_drain_empty", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h41200000;
    @(posedge clk); #1;
    in_data = 32'h41A00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized stream with random valid and ready
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_fp();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_all_sent", 32'(sent), 32'd10000);

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
